// File: rtl/food_gen_if.sv
// Bundles the snake-stage, VGA-scan and score signals of the food generator.
// Combinational container only; no latency and no backpressure.
// The generator uses the slave modport; the snake/VGA side uses master.
interface food_gen_if;
    logic [1:0] game_status;
    logic [6:0] head_x;
    logic [6:0] head_y;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [6:0] apple_x;
    logic [6:0] apple_y;
    logic       add_cube;
    logic       apple_pix;
    logic [7:0] score;
    logic [3:0] grow_cnt;

    modport master (
        output game_status, head_x, head_y, x_pos, y_pos,
        input  apple_x, apple_y, add_cube, apple_pix, score, grow_cnt
    );

    modport slave (
        input  game_status, head_x, head_y, x_pos, y_pos,
        output apple_x, apple_y, add_cube, apple_pix, score, grow_cnt
    );
endinterface

// File: rtl/food_gen.sv
// Apple generator: eat detection, growth request, BCD score, LFSR placement in the field.
// Eat seen at one edge -> add_cube/score update at that edge; placement takes 1+ cycles per try.
// No backpressure; FOOD_TIMEOUT_EN adds an apple relocation timeout.
module food_gen #(
    parameter int          X_MIN     = 1,
    parameter int          X_MAX     = 75,
    parameter int          Y_MIN     = 1,
    parameter int          Y_MAX     = 58,
    parameter int          ADD_HOLD  = 4,
    parameter int          MAX_GROW  = 13,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          TIMEOUT   = 500_000_000
) (
    input logic        clk,
    input logic        rst,
    food_gen_if.slave  fif
);
    localparam int HW = (ADD_HOLD > 1) ? $clog2(ADD_HOLD) : 1;

    typedef enum logic [1:0] {INIT, ACTIVE, EAT, PLACE} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [6:0]    apple_x;
    logic [6:0]    apple_y;
    logic          add_cube;
    logic [7:0]    score;
    logic [3:0]    grow_cnt;
    logic [HW-1:0] hold_cnt;
`ifdef FOOD_TIMEOUT_EN
    logic [31:0]   age;
`endif

    logic [6:0] cx;
    logic [6:0] cy;
    logic       cand_ok;
    logic       play;
    logic       restart;
    logic       hit;

    assign cx      = lfsr[6:0];
    assign cy      = lfsr[14:8];
    assign play    = (fif.game_status == 2'b10);
    assign restart = (fif.game_status == 2'b00);
    assign hit     = (fif.head_x == apple_x) && (fif.head_y == apple_y);
    assign cand_ok = (cx >= 7'(X_MIN)) && (cx <= 7'(X_MAX)) &&
                     (cy >= 7'(Y_MIN)) && (cy <= 7'(Y_MAX)) &&
                     !((cx == fif.head_x) && (cy == fif.head_y));

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [3:0] u;
        logic [3:0] t;
        u = s[3:0];
        t = s[7:4];
        if (u == 4'd9) begin
            u = 4'd0;
            t = (t == 4'd9) ? 4'd0 : t + 4'd1;
        end else begin
            u = u + 4'd1;
        end
        return {t, u};
    endfunction

    // Free-running; only the hard reset reloads it, so a restart keeps the sequence going.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= LFSR_SEED;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            apple_x  <= 7'd40;
            apple_y  <= 7'd30;
            add_cube <= 1'b0;
            score    <= 8'h00;
            grow_cnt <= 4'd0;
            hold_cnt <= '0;
`ifdef FOOD_TIMEOUT_EN
            age      <= 32'd0;
`endif
        end else if (restart) begin
            state    <= INIT;
            apple_x  <= 7'd40;
            apple_y  <= 7'd30;
            add_cube <= 1'b0;
            score    <= 8'h00;
            grow_cnt <= 4'd0;
            hold_cnt <= '0;
`ifdef FOOD_TIMEOUT_EN
            age      <= 32'd0;
`endif
        end else begin
            case (state)
                INIT: begin
                    if (play) begin
                        state <= ACTIVE;
`ifdef FOOD_TIMEOUT_EN
                        age   <= 32'd0;
`endif
                    end
                end
                ACTIVE: begin
                    if (play) begin
                        if (hit) begin
                            state    <= EAT;
                            hold_cnt <= '0;
                            score    <= bcd_inc(score);
                            if (grow_cnt < 4'(MAX_GROW)) begin
                                grow_cnt <= grow_cnt + 4'd1;
                                add_cube <= 1'b1;
                            end
                        end
`ifdef FOOD_TIMEOUT_EN
                        else if (age == 32'(TIMEOUT - 1)) begin
                            state <= PLACE;
                        end else begin
                            age <= age + 32'd1;
                        end
`endif
                    end
                end
                EAT: begin
                    if (hold_cnt == HW'(ADD_HOLD - 1)) begin
                        state    <= PLACE;
                        add_cube <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                PLACE: begin
                    if (cand_ok) begin
                        apple_x <= cx;
                        apple_y <= cy;
                        state   <= ACTIVE;
`ifdef FOOD_TIMEOUT_EN
                        age     <= 32'd0;
`endif
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign fif.apple_x   = apple_x;
    assign fif.apple_y   = apple_y;
    assign fif.add_cube  = add_cube;
    assign fif.score     = score;
    assign fif.grow_cnt  = grow_cnt;
    // Coordinates are stale while searching, so the apple is hidden in PLACE.
    assign fif.apple_pix = (fif.x_pos[9:3] == apple_x) && (fif.y_pos[9:3] == apple_y) &&
                           (fif.x_pos < 10'd640) && (fif.y_pos < 10'd480) &&
                           (state != PLACE);
endmodule

// File: tb/tb_food_gen.sv
// Randomized directed bench for food_gen against a score/growth/placement reference model.
module tb_food_gen;
    localparam int          MAXG = 13;
    localparam int          HOLD = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    food_gen_if fif();
    food_gen dut (.clk(clk), .rst(rst), .fif(fif.slave));

    int n_cmp = 0;
    int n_err = 0;
    int eats;
    logic [6:0]  ax;
    logic [6:0]  ay;
    logic [15:0] m;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= SEED;
        else      m <= lfsr_next(m);
    end

    function automatic logic [7:0] bcd_of(input int n);
        int k;
        k = n % 100;
        return {4'(k / 10), 4'(k % 10)};
    endfunction

    function automatic int grow_of(input int n);
        return (n > MAXG) ? MAXG : n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_score"}, 32'(fif.score), 32'(bcd_of(eats)));
        check({tag, "_grow"},  32'(fif.grow_cnt), 32'(grow_of(eats)));
        check({tag, "_ax"},    32'(fif.apple_x), 32'(ax));
        check({tag, "_ay"},    32'(fif.apple_y), 32'(ay));
    endtask

    task automatic rand_head();
        logic [6:0] hx;
        logic [6:0] hy;
        hx = 7'($urandom_range(1, 75));
        hy = 7'($urandom_range(1, 58));
        if (hx == ax && hy == ay) hx = (hx == 7'd75) ? 7'd1 : hx + 7'd1;
        fif.head_x = hx;
        fif.head_y = hy;
    endtask

    task automatic idle(input int n);
        int x;
        int y;
        bit exp_pix;
        for (int i = 0; i < n; i++) begin
            rand_head();
            fif.game_status = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'b10;
            if ($urandom_range(0, 1) == 0) begin
                x = int'(ax) * 8 + int'($urandom_range(0, 7));
                y = int'(ay) * 8 + int'($urandom_range(0, 7));
            end else begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 1023));
            end
            fif.x_pos = 10'(x);
            fif.y_pos = 10'(y);
            #1;
            exp_pix = (x / 8 == int'(ax)) && (y / 8 == int'(ay)) && x < 640 && y < 480;
            check("idle_pix", 32'(fif.apple_pix), 32'(exp_pix));
            tick();
            check("idle_add", 32'(fif.add_cube), 32'd0);
            check("idle_ax", 32'(fif.apple_x), 32'(ax));
            check("idle_ay", 32'(fif.apple_y), 32'(ay));
        end
        fif.game_status = 2'b10;
    endtask

    // Head on the apple for one cycle, then a full growth pulse and relocation.
    task automatic eat();
        bit         g;
        bit         found;
        bit         v;
        logic [6:0] cx;
        logic [6:0] cy;
        g = (eats < MAXG);
        fif.game_status = 2'b10;
        fif.head_x = ax;
        fif.head_y = ay;
        tick();
        eats++;
        rand_head();
        check("eat_add1", 32'(fif.add_cube), 32'(g));
        check_model("eat");
        for (int i = 2; i <= HOLD; i++) begin
            tick();
            check("eat_addn", 32'(fif.add_cube), 32'(g));
        end
        fif.x_pos = {ax, 3'd2};
        fif.y_pos = {ay, 3'd6};
        tick();
        check("eat_add_end", 32'(fif.add_cube), 32'd0);
        check("place_pix", 32'(fif.apple_pix), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 256 && !found; k++) begin
            cx = m[6:0];
            cy = m[14:8];
            v = (cx >= 7'd1) && (cx <= 7'd75) && (cy >= 7'd1) && (cy <= 7'd58) &&
                !(cx == fif.head_x && cy == fif.head_y);
            tick();
            if (v) begin
                found = 1'b1;
                ax = cx;
                ay = cy;
            end
        end
        check("place_found", 32'(found), 32'd1);
        check("place_ax", 32'(fif.apple_x), 32'(ax));
        check("place_ay", 32'(fif.apple_y), 32'(ay));
        check("place_add", 32'(fif.add_cube), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        fif.game_status = 2'b00;
        fif.head_x = 7'd10;
        fif.head_y = 7'd5;
        fif.x_pos = 10'd323;
        fif.y_pos = 10'd245;
        eats = 0;
        ax = 7'd40;
        ay = 7'd30;
        #12;
        check_model("rst");
        check("rst_add", 32'(fif.add_cube), 32'd0);
        check("rst_pix", 32'(fif.apple_pix), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        fif.game_status = 2'b10;
        tick();
        check_model("active");
        check("active_add", 32'(fif.add_cube), 32'd0);
        idle(5);

        // Coincidence under a frozen status must not count as an eat.
        fif.game_status = 2'b11;
        fif.head_x = ax;
        fif.head_y = ay;
        tick();
        tick();
        check("frozen_add", 32'(fif.add_cube), 32'd0);
        check("frozen_score", 32'(fif.score), 32'd0);

        eat();
        while (eats < 14) begin
            idle(int'($urandom_range(0, 3)));
            eat();
        end
        check("sat_grow", 32'(fif.grow_cnt), 32'd13);
        check("sat_score", 32'(fif.score), 32'h14);

        while (eats < 100) begin
            idle(int'($urandom_range(0, 2)));
            eat();
        end
        check("wrap_score", 32'(fif.score), 32'h00);

        fif.game_status = 2'b00;
        tick();
        eats = 0;
        ax = 7'd40;
        ay = 7'd30;
        check_model("restart");
        fif.game_status = 2'b10;
        fif.head_x = 7'd40;
        fif.head_y = 7'd30;
        tick();
        check("init_no_eat", 32'(fif.add_cube), 32'd0);
        eat();

        // Restart on the second add_cube cycle truncates the pulse.
        fif.head_x = ax;
        fif.head_y = ay;
        tick();
        rand_head();
        check("mid_add1", 32'(fif.add_cube), 32'd1);
        tick();
        check("mid_add2", 32'(fif.add_cube), 32'd1);
        fif.game_status = 2'b00;
        tick();
        eats = 0;
        ax = 7'd40;
        ay = 7'd30;
        check("mid_rst_add", 32'(fif.add_cube), 32'd0);
        check_model("mid_rst");
        tick();
        check("mid_rst_hold", 32'(fif.add_cube), 32'd0);
        check_model("mid_rst_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/food_gen.md
Name: food_gen

Overview:
- Food (apple) generator for the greedy-snake game. It consumes the head position and game status from the snake movement stage. It produces the growth request `add_cube` for that stage, the apple grid position, an apple pixel flag for the VGA colour mux, and a 2-digit BCD score.
- Placement is pseudo-random from a free-running LFSR and is constrained to the playable field inside the wall.

Parameters:
- X_MIN, 1, lowest legal apple column (grid units).
- X_MAX, 75, highest legal apple column.
- Y_MIN, 1, lowest legal apple row.
- Y_MAX, 58, highest legal apple row.
- ADD_HOLD, 4, number of clk cycles `add_cube` is held high per eat (≥2).
- MAX_GROW, 13, maximum number of growth requests per game (3 initial + 13 = 16 segments).
- LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero).
- TIMEOUT, 500_000_000, relocation timeout in clk cycles (used only with FOOD_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- game_status  in  2  00=RESTART, 10=PLAY, other codes=frozen
- head_x  in  7  snake head column (grid units)
- head_y  in  7  snake head row (grid units)
- x_pos  in  10  VGA scan x (pixels)
- y_pos  in  10  VGA scan y (pixels)
- apple_x  out  7  current apple column
- apple_y  out  7  current apple row
- add_cube  out  1  growth request level, held ADD_HOLD cycles
- apple_pix  out  1  scan pixel lies inside the apple cell
- score  out  8  BCD score, [7:4]=tens, [3:0]=units
- grow_cnt  out  4  growth requests issued this game

Behaviour:
- Reset is rst asynchronous, active-low; clock clk. Reset applies to every register.
- Reset values:
  - state=INIT, apple_x=40, apple_y=30, add_cube=0, score=8'h00, grow_cnt=0, lfsr=LFSR_SEED.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk regardless of state, including while game_status==RESTART. It is reloaded only by rst.
- Candidate position: cx=lfsr[6:0], cy=lfsr[14:8].
- A candidate is valid when all of these hold: X_MIN≤cx≤X_MAX, Y_MIN≤cy≤Y_MAX, and !(cx==head_x && cy==head_y).
- FSM states: INIT, ACTIVE, EAT, PLACE.
  - INIT: apple is held at (40,30). Go to ACTIVE when game_status==PLAY.
  - ACTIVE: when game_status==PLAY and head_x==apple_x and head_y==apple_y, go to EAT next cycle. In non-PLAY, non-RESTART status, hold everything.
  - EAT:
    - Entry cycle: score increments by 1 in BCD (09→10, 99→00 wrap).
    - If grow_cnt<MAX_GROW: add_cube=1 for exactly ADD_HOLD cycles, and grow_cnt increments once on entry.
    - If grow_cnt==MAX_GROW: add_cube stays 0 and grow_cnt saturates; score still increments.
    - After ADD_HOLD cycles, go to PLACE with add_cube=0.
  - PLACE: each cycle, test the candidate. If valid, latch apple_x=cx, apple_y=cy and go to ACTIVE. Otherwise stay in PLACE; the next LFSR value is tried next cycle.
- Eat detection fires once per apple. While in EAT/PLACE, further coincidence is ignored.
- RESTART (game_status==00):
  - Applies from any state on the next clk edge: state=INIT, apple=(40,30), add_cube=0, score=0, grow_cnt=0.
  - A restart in the middle of EAT truncates the add_cube pulse immediately.
- add_cube timing: low for at least 1 cycle between consecutive pulses. This is guaranteed because EAT→PLACE→ACTIVE→EAT takes at least 2 cycles.
- apple_pix is combinational:
  - High when x_pos[9:3]==apple_x, y_pos[9:3]==apple_y, x_pos<640 and y_pos<480.
  - Forced 0 in PLACE, since apple_x/apple_y are stale.
- Widths: apple comparisons are 7-bit unsigned. The BCD units digit rolls 9→0 with a carry into tens.

Optional Feature:
- Macro FOOD_TIMEOUT_EN.
- Defined:
  - A 32-bit age counter clears on every entry to ACTIVE and counts while in ACTIVE with game_status==PLAY.
  - On reaching TIMEOUT-1 without an eat, go directly to PLACE. There is no score change and add_cube stays 0.
  - An eat on the same cycle as the timeout takes priority (go to EAT).
- Not defined: no counter is present; the apple stays in ACTIVE until eaten or restarted.

Test Plan:
- Reset then PLAY, head=(10,5): apple=(40,30), score=00, add_cube=0, state ACTIVE after 1 cycle.
- PLAY, drive head=(40,30) for 1 cycle: add_cube high for exactly 4 cycles starting 1 cycle later, score=01, grow_cnt=1; then new apple in [1..75]×[1..58], ≠(40,30) head, within 256 cycles.
- Eat 14 apples in succession: grow_cnt saturates at 13, 14th eat gives add_cube=0, score=8'h14.
- Preload score to 99 via 99 eats: 100th eat → score=8'h00.
- RESTART asserted on the 2nd cycle of add_cube: add_cube=0 next cycle, score=00, apple=(40,30), state INIT.
- FOOD_TIMEOUT_EN, TIMEOUT=100, no eat: after 100 PLAY cycles in ACTIVE the apple relocates, score unchanged, add_cube never high.
